// File: rtl/instruction_fetch_stage_pkg.sv
// instruction_fetch_stage_pkg: shared pipeline types and defaults for the fetch stage and its consumers
// Contents: default widths, bubble word, IF/ID record, fetch state encoding.
package instruction_fetch_stage_pkg;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int DATA_WIDTH_DEF = 32;
  localparam logic [DATA_WIDTH_DEF-1:0] NOP_WORD_DEF = 32'h0000_0000;
  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] instruction;
    logic [ADDR_WIDTH_DEF-1:0] pc_plus1;
    logic                      valid;
  } if_id_t;
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/instruction_fetch_stage_pc_register.sv
// instruction_fetch_stage_pc_register: program counter with reset, redirect load, hold and increment
// Ports: clk, rst (sync, active-high), load/target (redirect), inc (advance by one), pc (current value).
module instruction_fetch_stage_pc_register #(
  parameter int W = 6,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] target,
  input  logic         inc,
  output logic [W-1:0] pc
);
  always_ff @(posedge clk)
    if (rst) pc <= RESET_PC;
    else pc <= load ? target : inc ? pc + W'(1) : pc;
endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: MIPS IF stage owning the PC and the IF/ID register, with stall, redirect and halt
// Ports: clk, rst (sync, active-high); stall, branch_taken/branch_target, halt from later stages;
// instruction_address/instruction to and from instruction memory (same-cycle read);
// if_id_instruction, if_id_pc_plus1, if_id_valid to ID; fetch_count (saturating), halted.
import instruction_fetch_stage_pkg::*;

module instruction_fetch_stage #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] instruction_address,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] if_id_instruction,
  output logic [ADDR_WIDTH-1:0] if_id_pc_plus1,
  output logic                  if_id_valid,
  output logic [15:0]           fetch_count,
  output logic                  halted
);
  fetch_state_e state, state_next;
  logic run, redirect, hold, fire;
  logic [ADDR_WIDTH-1:0] pc;
  always_comb begin
    run        = state == RUN;
    redirect   = run & branch_taken;
    hold       = run & ~branch_taken & ~halt & stall;
    fire       = run & ~branch_taken & ~halt & ~stall;
    state_next = state == BOOT ? (halt ? HALTED : RUN) :
                 run           ? (!branch_taken && halt ? HALTED : RUN) :
                                 HALTED;
  end
  always_ff @(posedge clk)
    if (rst) state <= BOOT;
    else state <= state_next;
  instruction_fetch_stage_pc_register #(.W(ADDR_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .rst    (rst),
    .load   (redirect),
    .target (branch_target),
    .inc    (fire),
    .pc     (pc)
  );
  assign instruction_address = pc;
  assign halted = state == HALTED;
  // Every non-fetching, non-holding cycle (boot, redirect, halt, halted) writes a bubble.
  always_ff @(posedge clk)
    if (rst) begin
      if_id_instruction <= NOP_WORD;
      if_id_pc_plus1    <= '0;
      if_id_valid       <= 1'b0;
      fetch_count       <= '0;
    end else if (fire) begin
      if_id_instruction <= instruction;
      if_id_pc_plus1    <= pc + ADDR_WIDTH'(1);
      if_id_valid       <= 1'b1;
      fetch_count       <= fetch_count + 16'(fetch_count != 16'hFFFF);
    end else if (!hold) begin
      if_id_instruction <= NOP_WORD;
      if_id_pc_plus1    <= '0;
      if_id_valid       <= 1'b0;
    end
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: table-driven check of the fetch stage against hand-computed IF/ID sequences
module tb_instruction_fetch_stage;
  logic        clk = 0;
  logic        rst = 0;
  logic        stall = 0;
  logic        branch_taken = 0;
  logic [5:0]  branch_target = 0;
  logic        halt = 0;
  logic [5:0]  instruction_address;
  logic [31:0] instruction;
  logic [31:0] if_id_instruction;
  logic [5:0]  if_id_pc_plus1;
  logic        if_id_valid;
  logic [15:0] fetch_count;
  logic        halted;
  int          passed = 0;
  int          total = 0;

  instruction_fetch_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .halt                (halt),
    .instruction_address (instruction_address),
    .instruction         (instruction),
    .if_id_instruction   (if_id_instruction),
    .if_id_pc_plus1      (if_id_pc_plus1),
    .if_id_valid         (if_id_valid),
    .fetch_count         (fetch_count),
    .halted              (halted)
  );

  always #5 clk = ~clk;
  always_comb instruction = 32'h1000_0000 + {26'd0, instruction_address};

  typedef struct {
    logic        st, br, hl;
    logic [5:0]  tgt;
    logic [5:0]  addr;
    logic [31:0] instr;
    logic [5:0]  pc1;
    logic        valid;
    logic [15:0] cnt;
    logic        hlt;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic st, br, hl, input logic [5:0] tgt, addr, input logic [31:0] instr,
                     input logic [5:0] pc1, input logic valid, input logic [15:0] cnt, input logic hlt);
    vec_t v;
    v.st = st; v.br = br; v.hl = hl; v.tgt = tgt; v.addr = addr; v.instr = instr;
    v.pc1 = pc1; v.valid = valid; v.cnt = cnt; v.hlt = hlt;
    vecs.push_back(v);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " addr"}, 32'(instruction_address), 32'd0);
    chk({tag, " instr"}, if_id_instruction, 32'h0);
    chk({tag, " pc1"}, 32'(if_id_pc_plus1), 32'd0);
    chk({tag, " valid"}, 32'(if_id_valid), 32'd0);
    chk({tag, " cnt"}, 32'(fetch_count), 32'd0);
    chk({tag, " halted"}, 32'(halted), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1; stall = 0; branch_taken = 0; halt = 0; branch_target = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    // st br hl tgt | addr instr pc1 valid cnt halted
    add(0,0,0, 0,  0, 32'h0,          0, 0, 0,  0);
    for (int i = 0; i < 5; i++)
      add(0,0,0, 0, 6'(i+1), 32'h1000_0000 + i, 6'(i+1), 1, 16'(i+1), 0);
    for (int i = 0; i < 3; i++)
      add(1,0,0, 0,  5, 32'h1000_0004, 5, 1, 5,  0);
    add(0,0,0, 0,  6, 32'h1000_0005, 6, 1, 6,  0);
    add(0,0,0, 0,  7, 32'h1000_0006, 7, 1, 7,  0);
    add(1,1,0, 40, 40, 32'h0,        0, 0, 7,  0);
    add(0,0,0, 0, 41, 32'h1000_0028, 41, 1, 8, 0);
    add(0,1,0, 63, 63, 32'h0,        0, 0, 8,  0);
    add(0,0,0, 0,  0, 32'h1000_003F, 0, 1, 9,  0);
    add(0,0,0, 0,  1, 32'h1000_0000, 1, 1, 10, 0);
    add(0,1,0, 12, 12, 32'h0,        0, 0, 10, 0);
    add(0,0,1, 0, 12, 32'h0,         0, 0, 10, 1);
    add(1,1,0, 3, 12, 32'h0,         0, 0, 10, 1);
    add(0,0,1, 0, 12, 32'h0,         0, 0, 10, 1);
    add(0,0,0, 0, 12, 32'h0,         0, 0, 10, 1);

    do_reset();
    check_reset("reset");
    foreach (vecs[i]) begin
      stall = vecs[i].st; branch_taken = vecs[i].br; halt = vecs[i].hl; branch_target = vecs[i].tgt;
      @(posedge clk); #1;
      chk($sformatf("v%0d addr", i), 32'(instruction_address), 32'(vecs[i].addr));
      chk($sformatf("v%0d instr", i), if_id_instruction, vecs[i].instr);
      chk($sformatf("v%0d pc1", i), 32'(if_id_pc_plus1), 32'(vecs[i].pc1));
      chk($sformatf("v%0d valid", i), 32'(if_id_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d cnt", i), 32'(fetch_count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d halted", i), 32'(halted), 32'(vecs[i].hlt));
    end
    stall = 0; branch_taken = 0; halt = 0;

    do_reset();
    check_reset("rst from halt");

    // branch and halt together: branch wins, stage keeps running
    @(posedge clk); #1;
    branch_taken = 1; halt = 1; branch_target = 6'd20;
    @(posedge clk); #1;
    branch_taken = 0; halt = 0;
    chk("br+halt addr", 32'(instruction_address), 32'd20);
    chk("br+halt halted", 32'(halted), 32'd0);
    @(posedge clk); #1;
    chk("br+halt next", if_id_instruction, 32'h1000_0014);

    // halt during boot goes straight to HALTED
    do_reset();
    halt = 1;
    @(posedge clk); #1;
    halt = 0;
    chk("boot halt", 32'(halted), 32'd1);
    @(posedge clk); #1;
    chk("boot halt addr", 32'(instruction_address), 32'd0);

    // saturation: 65535 fetches reach the ceiling, further fetches keep it there
    do_reset();
    for (int i = 0; i < 65536; i++) @(posedge clk);
    #1;
    chk("sat reach", 32'(fetch_count), 32'hFFFF);
    for (int i = 0; i < 3; i++) begin
      logic [5:0] prev;
      @(posedge clk); #1;
      prev = instruction_address - 6'd1;
      chk($sformatf("sat hold %0d", i), 32'(fetch_count), 32'hFFFF);
      chk($sformatf("sat valid %0d", i), 32'(if_id_valid), 32'd1);
      chk($sformatf("sat instr %0d", i), if_id_instruction, 32'h1000_0000 + {26'd0, prev});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
IF stage of the five-stage MIPS pipeline and the requesting end of the instruction memory interface. It owns the program counter and drives the word address to instruction memory. The memory returns the 32-bit instruction combinationally in the same cycle, and this block registers it into the IF/ID pipeline register. It handles stall (hold), branch redirect (flush), and halt.

Parameters:
ADDR_WIDTH, 6, word-address width of instruction memory (64 words)
DATA_WIDTH, 32, instruction width
RESET_PC, 0, word address fetched first after reset
NOP_WORD, 32'h0000_0000, bubble word inserted into IF/ID on flush or bubble

Ports:
clk  in  1  pipeline clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard-unit stall; hold PC and IF/ID
branch_taken  in  1  redirect request from later stage
branch_target  in  ADDR_WIDTH  redirect word address
halt  in  1  stop fetching; sticky until rst
instruction_address  out  ADDR_WIDTH  word address to instruction memory, equal to pc (combinational)
instruction  in  DATA_WIDTH  instruction returned by memory, same cycle
if_id_instruction  out  DATA_WIDTH  registered instruction
if_id_pc_plus1  out  ADDR_WIDTH  registered pc+1 (word units)
if_id_valid  out  1  IF/ID holds a real instruction
fetch_count  out  16  instructions accepted into IF/ID, saturating
halted  out  1  high in HALTED state

Behaviour:
- Reset (rst=1 at a posedge) overrides everything:
  - pc=RESET_PC, state=BOOT
  - if_id_instruction=NOP_WORD, if_id_pc_plus1=0, if_id_valid=0
  - fetch_count=0, halted=0
- State machine: BOOT, RUN, HALTED.
- BOOT:
  - One bubble cycle: IF/ID loads NOP_WORD with valid=0. pc is unchanged.
  - Next state is RUN unconditionally, unless halt=1, which goes to HALTED.
- RUN: per-cycle priority is branch_taken > halt > stall > normal.
  - branch_taken: pc<=branch_target; IF/ID <= NOP_WORD, valid=0, pc_plus1=0 (flushes the wrong-path fetch). This applies even if stall=1 in the same cycle. fetch_count is unchanged.
  - halt: IF/ID <= NOP_WORD, valid=0; pc held; next state HALTED.
  - stall: pc and all IF/ID fields hold their values; fetch_count unchanged.
  - normal: IF/ID <= {instruction, pc+1, valid=1}; pc<=pc+1; fetch_count += 1, saturating at 16'hFFFF.
- HALTED:
  - pc held; IF/ID <= NOP_WORD with valid=0 every cycle; halted=1.
  - stall, branch_taken and halt are ignored. Only rst exits.
- PC arithmetic:
  - ADDR_WIDTH-bit modulo: pc=2^ADDR_WIDTH-1 increments to 0.
  - if_id_pc_plus1 wraps the same way.
  - branch_target is taken verbatim.
- Latency: the instruction at pc appears on if_id_instruction one cycle after instruction_address=pc, given no stall or redirect.
- instruction_address is a pure function of the pc register. There is no combinational path from stall, branch_taken or instruction to it.
- instruction is sampled only in the RUN normal case. Its value in other cycles has no effect.

Decomposition:
- Shared pipeline package holds:
  - ADDR_WIDTH and DATA_WIDTH defaults
  - NOP_WORD
  - the IF/ID record fields (instruction, pc_plus1, valid), reused by the ID stage
  - the fetch state encoding (BOOT=2'd0, RUN=2'd1, HALTED=2'd2)
- One natural sub-module: pc_register. It holds pc with reset, load (redirect), hold (stall/halt) and increment, and keeps the next-PC mux out of the IF/ID logic.
- Everything else stays flat in instruction_fetch_stage.

Test Plan:
- Reset then run, with memory word n = 32'h1000_0000+n:
  - cycle 1 after reset: valid=0 (BOOT)
  - then if_id_instruction = 32'h1000_0000, 32'h1000_0001, ...
  - if_id_pc_plus1 = 1, 2, ...
  - fetch_count increments by 1 per cycle
- Stall 3 cycles with pc=5: instruction_address stays 5; IF/ID and fetch_count frozen. On release, the next IF/ID value is word 5 with pc_plus1=6.
- branch_taken=1, branch_target=6'd40, asserted together with stall=1 at pc=7:
  - next cycle: pc=40, valid=0, if_id_instruction=NOP_WORD
  - following cycle: word 40 with pc_plus1=41
- Wrap: start at pc=63 (via branch) -> IF/ID gets word 63 with pc_plus1=0, and the next instruction_address is 0.
- halt at pc=12:
  - valid drops to 0 and halted=1 the next cycle
  - pc stays 12 even though branch_taken=1 to target 3 is applied
  - rst returns to pc=RESET_PC, BOOT, fetch_count=0
- Saturation: preload fetch_count near max via a long run (or force) -> it holds at 16'hFFFF while fetching continues normally.
